key_tracker: RTL

//  Game-side producer of the key_find / isDark signals used by the object renderer.

---
 rtl/game_pkg.sv | 45 ++++
 rtl/hitbox_cmp.sv | 28 ++
 rtl/key_tracker.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared game definitions for the key tracker.
// Contents:
//   game_state_e - top-level game state encoding (StTitle = 0 .. StFail = 8)
//   key_state_e  - key collection progress; the value is the key_find output
//   Hitbox corners (inclusive low corner) and the common 20x20 box size
//   is_stage()   - true for the three playable stages
package game_pkg;

  typedef enum logic [3:0] {
    StTitle  = 4'd0,
    StStage1 = 4'd1,
    StStage2 = 4'd2,
    StStage3 = 4'd3,
    StClear1 = 4'd4,
    StClear2 = 4'd5,
    StClear3 = 4'd6,
    StWin    = 4'd7,
    StFail   = 4'd8
  } game_state_e;

  // Encoded so the state value is directly the number of keys collected.
  typedef enum logic [1:0] {
    KeyIdx0 = 2'd0,
    KeyIdx1 = 2'd1,
    KeyIdx2 = 2'd2,
    KeyDone = 2'd3
  } key_state_e;

  localparam logic [8:0] BoxW    = 9'd20;
  localparam logic [8:0] BoxH    = 9'd20;

  localparam logic [8:0] Key0X0  = 9'd65;
  localparam logic [8:0] Key0Y0  = 9'd35;
  localparam logic [8:0] Key1X0  = 9'd230;
  localparam logic [8:0] Key1Y0  = 9'd35;
  localparam logic [8:0] Key2X0  = 9'd230;
  localparam logic [8:0] Key2Y0  = 9'd205;
  localparam logic [8:0] LightX0 = 9'd180;
  localparam logic [8:0] LightY0 = 9'd135;

  function automatic logic is_stage(logic [3:0] s);
    return (s == StStage1) || (s == StStage2) || (s == StStage3);
  endfunction

endpackage

// File: rtl/hitbox_cmp.sv
// Combinational rectangle test.
// Ports:
//   x, y    in  9  point under test
//   x0, y0  in  9  rectangle corner (inclusive)
//   w, h    in  9  rectangle size; x0+w / y0+h are exclusive
//   in_box  out 1  point lies inside the rectangle
module hitbox_cmp (
  input  logic [8:0] x,
  input  logic [8:0] y,
  input  logic [8:0] x0,
  input  logic [8:0] y0,
  input  logic [8:0] w,
  input  logic [8:0] h,
  output logic       in_box
);

  // One extra bit so x0+w cannot wrap near the 9-bit limit.
  logic [9:0] x_hi;
  logic [9:0] y_hi;

  always_comb begin
    x_hi   = {1'b0, x0} + {1'b0, w};
    y_hi   = {1'b0, y0} + {1'b0, h};
    in_box = (x >= x0) && ({1'b0, x} < x_hi) &&
             (y >= y0) && ({1'b0, y} < y_hi);
  end

endmodule

// File: rtl/key_tracker.sv
// Key collection and STAGE2 light tracker.
// Consumes one-cycle click strobes in 320x240 object coordinates and the game state,
// advances through three keys, toggles the STAGE2 light and pulses stage_clear when the
// last key is taken. All outputs are registered (one cycle of latency from a click).
// Parameters:
//   LIGHT_ON_CYCLES  light auto-off timeout in clk cycles (only with LIGHT_TIMEOUT_EN)
// Ports:
//   clk          in   1  system clock
//   rst          in   1  synchronous active-high reset
//   state        in   4  game state (game_state_e)
//   click        in   1  one-cycle click strobe
//   click_x      in   9  click x, 0..319
//   click_y      in   9  click y, 0..239
//   key_find     out  2  keys collected (3 = all found)
//   isDark       out  1  1 = STAGE2 light off
//   hit          out  1  one-cycle pulse: click consumed
//   stage_clear  out  1  one-cycle pulse when key_find goes 2->3
// Build option:
//   LIGHT_TIMEOUT_EN  when defined, the light switches itself off LIGHT_ON_CYCLES cycles after
//                     being turned on.
module key_tracker
  import game_pkg::*;
#(
  parameter logic [31:0] LIGHT_ON_CYCLES = 32'd50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] state,
  input  logic       click,
  input  logic [8:0] click_x,
  input  logic [8:0] click_y,
  output logic [1:0] key_find,
  output logic       isDark,
  output logic       hit,
  output logic       stage_clear
);

  key_state_e key_q, key_d;
  logic       dark_q, dark_d;
  logic       hit_q, hit_d;
  logic       clear_q, clear_d;
  logic [3:0] prev_q;

  logic in_key0, in_key1, in_key2, in_light;
  logic key_box;
  logic in_stage, in_stage2, stage_entry;
  logic light_expire;

  hitbox_cmp u_key0_box (
    .x      (click_x),
    .y      (click_y),
    .x0     (Key0X0),
    .y0     (Key0Y0),
    .w      (BoxW),
    .h      (BoxH),
    .in_box (in_key0)
  );

  hitbox_cmp u_key1_box (
    .x      (click_x),
    .y      (click_y),
    .x0     (Key1X0),
    .y0     (Key1Y0),
    .w      (BoxW),
    .h      (BoxH),
    .in_box (in_key1)
  );

  hitbox_cmp u_key2_box (
    .x      (click_x),
    .y      (click_y),
    .x0     (Key2X0),
    .y0     (Key2Y0),
    .w      (BoxW),
    .h      (BoxH),
    .in_box (in_key2)
  );

  hitbox_cmp u_light_box (
    .x      (click_x),
    .y      (click_y),
    .x0     (LightX0),
    .y0     (LightY0),
    .w      (BoxW),
    .h      (BoxH),
    .in_box (in_light)
  );

  // Only the box of the next key to collect counts.
  always_comb begin
    key_box = 1'b0;
    unique case (key_q)
      KeyIdx0: key_box = in_key0;
      KeyIdx1: key_box = in_key1;
      KeyIdx2: key_box = in_key2;
      KeyDone: key_box = 1'b0;
      default: key_box = 1'b0;
    endcase
  end

  always_comb begin
    in_stage    = is_stage(state);
    in_stage2   = (state == StStage2);
    stage_entry = in_stage && (state != prev_q);
  end

`ifdef LIGHT_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;

  assign light_expire = !dark_q && (cnt_q == 32'd0);
`else
  logic unused_light_on_cycles;

  assign unused_light_on_cycles = ^LIGHT_ON_CYCLES;
  assign light_expire           = 1'b0;
`endif

  always_comb begin
    key_d   = key_q;
    dark_d  = dark_q;
    hit_d   = 1'b0;
    clear_d = 1'b0;
`ifdef LIGHT_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif

    if (stage_entry) begin
      // Entry wins over any click in the same cycle.
      key_d  = KeyIdx0;
      dark_d = 1'b1;
`ifdef LIGHT_TIMEOUT_EN
      cnt_d  = 32'd0;
`endif
    end else begin
      if (in_stage && click) begin
        if ((key_q != KeyDone) && key_box && !(in_stage2 && dark_q)) begin
          key_d   = key_state_e'(key_q + 2'd1);
          hit_d   = 1'b1;
          clear_d = (key_q == KeyIdx2);
        end else if (in_stage2 && in_light && !light_expire) begin
          dark_d = !dark_q;
          hit_d  = 1'b1;
        end
      end
`ifdef LIGHT_TIMEOUT_EN
      if (!dark_q) begin
        if (light_expire) begin
          dark_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end else if (!dark_d) begin
        cnt_d = LIGHT_ON_CYCLES - 32'd1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q   <= KeyIdx0;
      dark_q  <= 1'b1;
      hit_q   <= 1'b0;
      clear_q <= 1'b0;
      prev_q  <= StTitle;
`ifdef LIGHT_TIMEOUT_EN
      cnt_q   <= 32'd0;
`endif
    end else begin
      key_q   <= key_d;
      dark_q  <= dark_d;
      hit_q   <= hit_d;
      clear_q <= clear_d;
      prev_q  <= state;
`ifdef LIGHT_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign key_find    = key_q;
  assign isDark      = dark_q;
  assign hit         = hit_q;
  assign stage_clear = clear_q;

endmodule
